// File: rtl/control_ajuste_if.sv
// control_ajuste_if: button levels in, field-adjust pulses out, between the
// button synchronizers (master) and the adjustment sequencer (slave).
interface control_ajuste_if #(parameter int NUM_CAMPOS = 3);
  localparam int CW = $clog2(NUM_CAMPOS);
  logic enable, btn_up, btn_down, btn_left, btn_right;
  logic [CW-1:0] campo;
  logic suma, resta, cambio;
  modport master(output enable, btn_up, btn_down, btn_left, btn_right,
                 input campo, suma, resta, cambio);
  modport slave(input enable, btn_up, btn_down, btn_left, btn_right,
                output campo, suma, resta, cambio);
endinterface

// File: rtl/control_ajuste.sv
// control_ajuste: turns up/down/left/right levels into inc/dec pulses with
// hold-to-repeat, and steps the selected field index on left/right.
module control_ajuste #(
  parameter int NUM_CAMPOS    = 3,
  parameter int CNT_W         = 26,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input logic clk,
  input logic reset,
  control_ajuste_if.slave bus
);
  localparam int CW = $clog2(NUM_CAMPOS);
  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0]    LAST   = CW'(NUM_CAMPOS - 1);
  typedef enum logic [1:0] {IDLE, ESPERA_HOLD, REPETIR, ESPERA_SUELTA} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} cmd_t;
  state_t state;
  cmd_t cmd;
  logic [CNT_W-1:0] cnt;
  logic held, any;
  // only UP/DOWN ever reach the hold states, so the latched button is one of these two
  assign held = (cmd == UP) ? bus.btn_up : bus.btn_down;
  assign any  = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= UP;
      cnt       <= '0;
      bus.campo <= '0;
      bus.suma  <= 1'b0;
      bus.resta <= 1'b0;
      bus.cambio <= 1'b0;
    end else begin
      bus.suma   <= 1'b0;
      bus.resta  <= 1'b0;
      bus.cambio <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.btn_up) begin
              cmd <= UP;
              bus.suma <= 1'b1;
              cnt <= '0;
              state <= ESPERA_HOLD;
            end else if (bus.btn_down) begin
              cmd <= DOWN;
              bus.resta <= 1'b1;
              cnt <= '0;
              state <= ESPERA_HOLD;
            end else if (bus.btn_left) begin
              cmd <= LEFT;
              bus.campo <= (bus.campo == '0) ? LAST : bus.campo - 1'b1;
              bus.cambio <= 1'b1;
              state <= ESPERA_SUELTA;
            end else if (bus.btn_right) begin
              cmd <= RIGHT;
              bus.campo <= (bus.campo == LAST) ? '0 : bus.campo + 1'b1;
              bus.cambio <= 1'b1;
              state <= ESPERA_SUELTA;
            end
          end
          ESPERA_HOLD: begin
            if (!held) state <= ESPERA_SUELTA;
            else if (cnt == HOLD_T) begin
              bus.suma  <= (cmd == UP);
              bus.resta <= (cmd == DOWN);
              cnt <= '0;
              state <= REPETIR;
            end else cnt <= cnt + 1'b1;
          end
          REPETIR: begin
            if (!held) state <= ESPERA_SUELTA;
            else if (cnt == REP_T) begin
              bus.suma  <= (cmd == UP);
              bus.resta <= (cmd == DOWN);
              cnt <= '0;
            end else cnt <= cnt + 1'b1;
          end
          ESPERA_SUELTA: state <= any ? ESPERA_SUELTA : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/control_ajuste.md
# control_ajuste

Button-driven adjustment sequencer for the time/value setting path. It takes four debounced push-button levels (up, down, left, right) and turns them into single-cycle increment/decrement pulses for the shared field counters. It also tracks which field is under adjustment and auto-repeats while up/down is held. It sits between the button synchronizers and the field counter bank, which consumes `suma`/`resta` qualified by `campo`.

## Interface

Parameters:
- `NUM_CAMPOS`, 3: number of adjustable fields; `campo` ranges 0..NUM_CAMPOS-1.
- `CNT_W`, 26: width of the hold/repeat cycle counter.
- `HOLD_CYCLES`, 25_000_000: cycles up/down must stay held before auto-repeat starts; ≥1, < 2^CNT_W.
- `REPEAT_CYCLES`, 5_000_000: cycles between auto-repeat pulses; ≥1, < 2^CNT_W.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  adjustment mode active; when low, no pulses and no field changes.
- `btn_up`  in  1  level, already synchronized and debounced.
- `btn_down`  in  1  level, already synchronized and debounced.
- `btn_left`  in  1  level, already synchronized and debounced.
- `btn_right`  in  1  level, already synchronized and debounced.
- `campo`  out  $clog2(NUM_CAMPOS)  selected field index; registered.
- `suma`  out  1  one-cycle increment pulse for field `campo`; registered.
- `resta`  out  1  one-cycle decrement pulse for field `campo`; registered.
- `cambio`  out  1  one-cycle pulse when `campo` changes; registered.

## Operation

- FSM states: IDLE, ESPERA_HOLD, REPETIR, ESPERA_SUELTA. A 2-bit latched command `cmd` records UP, DOWN, LEFT or RIGHT.
- Reset (asynchronous): state=IDLE, `campo`=0, `suma`=`resta`=`cambio`=0, counter=0, `cmd`=UP.
- `suma`, `resta` and `cambio` default to 0 on every edge. They are high only on the edges listed below. `suma` and `resta` are never high together.
- IDLE with `enable`=1 and any button high:
  - Buttons are resolved by fixed priority up > down > left > right, and `cmd` latches the winner.
  - UP: `suma`<=1, counter<=0, go to ESPERA_HOLD.
  - DOWN: `resta`<=1, counter<=0, go to ESPERA_HOLD.
  - RIGHT: `campo`<=`campo`+1, wrapping NUM_CAMPOS-1→0. `cambio`<=1, go to ESPERA_SUELTA.
  - LEFT: `campo`<=`campo`-1, wrapping 0→NUM_CAMPOS-1. `cambio`<=1, go to ESPERA_SUELTA.
- ESPERA_HOLD:
  - If the latched button is released, go to ESPERA_SUELTA.
  - Otherwise, if counter==HOLD_CYCLES-1: pulse `suma` or `resta` per `cmd`, counter<=0, go to REPETIR.
  - Otherwise counter<=counter+1.
- REPETIR:
  - If the latched button is released, go to ESPERA_SUELTA.
  - Otherwise, if counter==REPEAT_CYCLES-1: pulse per `cmd` and set counter<=0.
  - Otherwise counter<=counter+1.
- ESPERA_SUELTA: go to IDLE once all four buttons are low. No new command is accepted until then, so a second button pressed during a hold never triggers.
- Only the latched button matters in ESPERA_HOLD and REPETIR. Other buttons are ignored.
- `enable` low, in any state: next state IDLE, counter<=0, no pulses. `campo` holds its value.
- Counter never wraps, because the terminal compare clears it first.

## Timing

- Press latency: a button sampled high at edge k in IDLE gives a pulse registered at edge k, high for the cycle k..k+1.
- First auto-repeat pulse at edge k+HOLD_CYCLES. Subsequent pulses at k+HOLD_CYCLES+n·REPEAT_CYCLES, n≥1.
- With HOLD_CYCLES=1 and REPEAT_CYCLES=1, auto-repeat pulses on every edge after k.
- Release at an edge where counter is terminal: the release wins and no pulse is emitted.
- Minimum press-to-press spacing: a full release must be seen in ESPERA_SUELTA, then IDLE is entered one edge later. Two separate presses therefore need at least one all-low sample between them.
- Reset asserted mid-hold clears outputs immediately (asynchronous). After deassertion the FSM is in IDLE; a still-held button generates a new first pulse on the next edge.

## Test plan

Bench parameters: NUM_CAMPOS=3, HOLD_CYCLES=4, REPEAT_CYCLES=2.

- Reset, then tap `btn_up` for 1 cycle → exactly one `suma` pulse one cycle wide; `campo`=0; state returns to IDLE.
- Hold `btn_down` 10 cycles from edge k → `resta` high at edges k, k+4, k+6, k+8; no `suma`; no pulse after release.
- Three `btn_right` taps separated by low cycles → `campo` 0→1→2→0, one `cambio` per tap. One `btn_left` tap from 0 → `campo`=2.
- `btn_up` and `btn_right` rising together, held → only `suma` pulses (priority up wins); `campo` unchanged. Release `btn_up` with `btn_right` still high → no field change until all buttons are released and then re-pressed.
- `enable`=0 with any button activity → no pulses, `campo` constant. Drop `enable` mid-hold at k+5 → no further pulses.
- Assert `reset` asynchronously mid-REPETIR → outputs 0 and `campo`=0 without a clock edge. Deassert with `btn_up` held → new `suma` on the next edge.
